// File: rtl/debug_dump_sequencer_pkg.sv
// debug_dump_pkg: shared FSM state encoding and ASCII framing constants for the debug dump sequencer.
package debug_dump_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_SELECT,
    S_SETTLE,
    S_CAPTURE,
    S_SEND,
    S_NEXT,
    S_DONE
  } state_t;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_P     = 8'h50;
  localparam logic [7:0] ASC_C     = 8'h43;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam int LINE_LEN = 13;
  localparam int HDR_LEN  = 7;
endpackage

// File: rtl/debug_dump_sequencer_if.sv
// debug_dump_sequencer_if: debug mux select/data and UART TX byte handshake bundle.
interface debug_dump_sequencer_if #(parameter int SEL_W = 5);
  logic [SEL_W-1:0] debug_sel;
  logic [31:0]      debug_data;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  modport master (output debug_sel, tx_data, tx_valid, input debug_data, tx_ready);
  modport slave  (input debug_sel, tx_data, tx_valid, output debug_data, tx_ready);
endinterface

// File: rtl/debug_dump_sequencer_hex_ascii.sv
// hex_ascii: combinational nibble to uppercase ASCII hex digit.
module hex_ascii (
  input  logic [3:0] i_nib,
  output logic [7:0] o_asc
);
  assign o_asc = (i_nib < 4'd10) ? 8'h30 + {4'd0, i_nib} : 8'h37 + {4'd0, i_nib};
endmodule

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: walks every debug source and streams one ASCII hex line per source to UART TX.
// Define DEBUG_DUMP_HEADER_EN to prefix the dump with a "PC=xx" line.
module debug_dump_sequencer
  import debug_dump_pkg::*;
#(
  parameter int NUM_SOURCES   = 32,
  parameter int SEL_W         = 5,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             pc,
  debug_dump_sequencer_if.master bus,
  output logic                   busy,
  output logic                   done
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  state_t           r_state, w_next;
  logic [7:0]       r_idx;
  logic [SW-1:0]    r_set;
  logic [3:0]       r_cnt;
  logic [31:0]      r_word;
  logic [SEL_W-1:0] r_sel;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             w_xfer, w_last, w_hdr, w_load;
  logic [3:0]       w_k, w_nib;
  logic [2:0]       w_sh;
  logic [7:0]       w_hex, w_byte, w_pc;
`ifdef DEBUG_DUMP_HEADER_EN
  localparam bit HDR = 1'b1;
  logic [7:0] r_pc;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_pc <= '0;
    else        r_pc <= (r_state == S_IDLE && start) ? pc : r_pc;
  assign w_pc = r_pc;
`else
  localparam bit HDR = 1'b0;
  logic w_unused;
  assign w_unused = &{1'b0, pc};
  assign w_pc = 8'h00;
`endif
  assign busy          = r_state != S_IDLE;
  assign done          = r_state == S_DONE;
  assign bus.debug_sel = r_sel;
  assign bus.tx_data   = r_data;
  assign bus.tx_valid  = r_valid;
  assign w_xfer = r_valid & bus.tx_ready;
  assign w_last = (r_state == S_HEADER) ? r_cnt == 4'(HDR_LEN - 1) : r_cnt == 4'(LINE_LEN - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = HDR ? S_HEADER : S_SELECT;
      S_HEADER:  if (w_xfer && w_last) w_next = S_SELECT;
      S_SELECT:  w_next = S_SETTLE;
      S_SETTLE:  if (r_set == SW'(SETTLE_CYCLES - 1)) w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_SEND;
      S_SEND:    if (w_xfer && w_last) w_next = S_NEXT;
      S_NEXT:    w_next = (r_idx == 8'(NUM_SOURCES - 1)) ? S_DONE : S_SELECT;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  // The byte register is always loaded one byte ahead: w_k is the index of the byte to present next.
  always_comb begin
    w_k    = (r_state == S_SEND || r_state == S_HEADER) ? r_cnt + 4'd1 : 4'd0;
    w_hdr  = HDR && (r_state == S_IDLE || r_state == S_HEADER);
    w_sh   = 3'(4'd10 - w_k);
    w_nib  = w_hdr ? (w_k == 4'd3 ? w_pc[7:4] : w_pc[3:0]) :
             w_k == 4'd0 ? r_idx[7:4] : w_k == 4'd1 ? r_idx[3:0] : r_word[{w_sh, 2'b00} +: 4];
    w_byte = w_hdr ? (w_k == 4'd0 ? ASC_P : w_k == 4'd1 ? ASC_C : w_k == 4'd2 ? ASC_EQ :
                      w_k == 4'd5 ? ASC_CR : w_k == 4'd6 ? ASC_LF : w_hex) :
                     (w_k == 4'd2 ? ASC_COLON : w_k == 4'd11 ? ASC_CR : w_k == 4'd12 ? ASC_LF : w_hex);
    w_load = r_state == S_CAPTURE || (HDR && r_state == S_IDLE && start) ||
             ((r_state == S_SEND || r_state == S_HEADER) && w_xfer && !w_last);
  end
  hex_ascii u_hex (.i_nib(w_nib), .o_asc(w_hex));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_idx   <= '0;
      r_set   <= '0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_sel   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_idx   <= (r_state == S_IDLE && start) ? 8'd0 : (r_state == S_NEXT && w_next == S_SELECT) ? r_idx + 8'd1 : r_idx;
      r_set   <= (r_state == S_SETTLE) ? r_set + SW'(1) : '0;
      r_cnt   <= (r_state == S_SEND || r_state == S_HEADER) ? (w_xfer ? r_cnt + 4'd1 : r_cnt) : 4'd0;
      r_word  <= (r_state == S_CAPTURE) ? bus.debug_data : r_word;
      r_sel   <= (w_next == S_IDLE) ? '0 : (r_state == S_SELECT) ? r_idx[SEL_W-1:0] : r_sel;
      r_valid <= w_load ? 1'b1 : (w_xfer && w_last) ? 1'b0 : r_valid;
      r_data  <= w_load ? w_byte : r_data;
    end
endmodule

// File: tb/tb_debug_dump_sequencer.sv
// tb_debug_dump_sequencer: directed dumps with randomized debug words and ready patterns against a line-format model.
module tb_debug_dump_sequencer;
  localparam int N = 32;
  localparam int S = 2;
`ifdef DEBUG_DUMP_HEADER_EN
  localparam int H = 7;
`else
  localparam int H = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [7:0] pc = 8'h2C;
  logic busy, done;
  logic [31:0] mem [N];
  int checks = 0, errors = 0, cyc = 0, mode = 0, dones = 0;
  logic [7:0] got [$];
  logic hold = 1'b0;
  logic [7:0] hold_d = 8'h00;

  debug_dump_sequencer_if #(.SEL_W(5)) bus();
  assign bus.debug_data = mem[bus.debug_sel];

  debug_dump_sequencer #(.NUM_SOURCES(N), .SEL_W(5), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    string d;
    d = "0123456789ABCDEF";
    return d[n];
  endfunction

  always @(negedge clk)
    if (reset) begin
      if (hold) chk("tx_hold", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, hold_d});
      if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
      if (done) dones++;
      hold = bus.tx_valid && !bus.tx_ready;
      hold_d = bus.tx_data;
    end else hold = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 4 == 0) : 1'($urandom_range(0, 1));
  endtask

  task automatic dump(input int md, input bit timing, input bit restart, input bit perturb, input int abort_at);
    logic [7:0] exp [$];
    int n;
    bit pulsed, pert;
    pulsed = 0;
    pert = 0;
    mode = md;
    if (H != 0) begin
      exp.push_back(8'h50); exp.push_back(8'h43); exp.push_back(8'h3D);
      exp.push_back(hx(pc[7:4])); exp.push_back(hx(pc[3:0]));
      exp.push_back(8'h0D); exp.push_back(8'h0A);
    end
    for (int i = 0; i < N; i++) begin
      exp.push_back(hx(4'(i >> 4)));
      exp.push_back(hx(4'(i)));
      exp.push_back(8'h3A);
      for (int j = 7; j >= 0; j--) exp.push_back(hx(mem[i][4*j +: 4]));
      exp.push_back(8'h0D);
      exp.push_back(8'h0A);
    end
    got.delete();
    dones = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (timing) begin
      tick();
      @(negedge clk);
      chk("busy_n1", {31'd0, busy}, 1);
      repeat (S) tick();
      @(negedge clk);
      chk("valid_pre", {31'd0, bus.tx_valid}, (H != 0) ? 1 : 0);
      tick();
      @(negedge clk);
      chk("valid_first", {31'd0, bus.tx_valid}, 1);
    end
    n = 0;
    while (dones == 0 && n < 6000) begin
      if (restart && !pulsed && got.size() == 100 + H) begin
        start = 1'b1;
        pulsed = 1;
      end
      if (perturb && !pert && got.size() == 5 * 13 + 4 + H) begin
        mem[5] = ~mem[5];
        pert = 1;
      end
      if (abort_at > 0 && got.size() == abort_at + H) begin
        #1 reset = 1'b0;
        #1;
        chk("rst_valid", {31'd0, bus.tx_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_sel", {27'd0, bus.debug_sel}, 0);
        tick();
        tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_no_done", dones, 0);
        chk("rst_idle_busy", {31'd0, busy}, 0);
        return;
      end
      tick();
      start = 1'b0;
      n++;
    end
    chk("dump_timeout", {31'd0, n < 6000}, 1);
    repeat (3) tick();
    chk("done_count", dones, 1);
    chk("busy_end", {31'd0, busy}, 0);
    chk("byte_count", got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk($sformatf("byte%0d", i), {24'd0, got[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    bus.tx_ready = 1'b1;
    foreach (mem[i]) mem[i] = $urandom;
    mem[3] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", {31'd0, bus.tx_valid}, 0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 0);
    chk("rst_busy0", {31'd0, busy}, 0);
    chk("rst_done0", {31'd0, done}, 0);
    chk("rst_sel0", {27'd0, bus.debug_sel}, 0);
    reset = 1'b1;
    tick();
    dump(0, 1, 0, 0, 0);
    dump(1, 0, 1, 0, 0);
    foreach (mem[i]) mem[i] = $urandom;
    dump(0, 0, 0, 1, 0);
    dump(0, 0, 0, 0, 10 * 13 + 6);
    dump(2, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
